// File: rtl/csi_rx_packet_decoder.sv
// csi_rx_packet_decoder: CSI-2 packet header ECC check, short/long split, payload extraction with CRC-16 strip/check (optional CRC engine: CSI_RX_CRC_EN)
module csi_rx_packet_decoder #(
  parameter logic [5:0] SHORT_DT_MAX = 6'h0F
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FSYNC,
  input  logic        VALID,
  input  logic [31:0] DIN,
  output logic        FS,
  output logic        FE,
  output logic        LS,
  output logic        LE,
  output logic        HDR_VALID,
  output logic [1:0]  VC,
  output logic [5:0]  DT,
  output logic [15:0] WC,
  output logic        PVALID,
  output logic [31:0] PDATA,
  output logic [3:0]  PBE,
  output logic        PLAST,
  output logic        ECC_ERR,
  output logic        CRC_ERR,
  output logic        PKT_ERR,
  output logic        BUSY
);
  typedef enum logic [1:0] {IDLE, LONG, TAIL} state_t;
  state_t state;
  logic [15:0] rem;
  logic ecc_ok;
  logic [3:0] last_be;
  logic crc_bad;

  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    ecc_calc = {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction

  assign ecc_ok = ecc_calc(DIN[23:0]) == DIN[31:24];
  assign last_be = rem >= 16'd4 ? 4'hF : (4'd1 << rem[1:0]) - 4'd1;
  assign BUSY = state != IDLE;

`ifdef CSI_RX_CRC_EN
  logic [15:0] crc, crc_pay, crc_rx;
  logic [7:0] crc_lo;
  logic one_left;
  logic [2:0] pay_n;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [31:0] d, input logic [2:0] n);
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 8; b++)
        if (k < int'(n)) c = {1'b0, c[15:1]} ^ ({16{c[0] ^ d[8*k+b]}} & 16'h8408);
    crc_upd = c;
  endfunction

  assign pay_n = state != LONG ? 3'd0 : rem > 16'd4 ? 3'd4 : rem[2:0];
  assign crc_pay = crc_upd(crc, DIN, pay_n);
  assign crc_rx = state == TAIL ? (one_left ? {DIN[7:0], crc_lo} : DIN[15:0])
                                : (rem == 16'd1 ? DIN[23:8] : DIN[31:16]);
  assign crc_bad = crc_pay != crc_rx;

  // Running CRC over payload bytes plus the split-CRC bookkeeping for the TAIL word
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      crc <= 16'hFFFF;
      crc_lo <= 8'h00;
      one_left <= 1'b0;
    end else if (VALID) begin
      crc <= FSYNC ? 16'hFFFF : crc_pay;
      crc_lo <= DIN[31:24];
      one_left <= !FSYNC && state == LONG ? rem == 16'd3 : FSYNC ? 1'b0 : one_left;
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  // Packet state machine with registered strobes and payload outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      rem <= 16'd0;
      {FS, FE, LS, LE, HDR_VALID, PVALID, PLAST, ECC_ERR, CRC_ERR, PKT_ERR} <= '0;
      VC <= '0;
      DT <= '0;
      WC <= '0;
      PDATA <= '0;
      PBE <= '0;
    end else begin
      {FS, FE, LS, LE, HDR_VALID, PVALID, PLAST, ECC_ERR, CRC_ERR, PKT_ERR} <= '0;
      if (VALID && FSYNC) begin
        PKT_ERR <= state != IDLE;
        ECC_ERR <= !ecc_ok;
        state <= IDLE;
        if (ecc_ok) begin
          HDR_VALID <= 1'b1;
          VC <= DIN[7:6];
          DT <= DIN[5:0];
          WC <= DIN[23:8];
          FS <= DIN[5:0] == 6'h00;
          FE <= DIN[5:0] == 6'h01;
          LS <= DIN[5:0] == 6'h02;
          LE <= DIN[5:0] == 6'h03;
          rem <= DIN[23:8];
          state <= DIN[5:0] <= SHORT_DT_MAX ? IDLE : DIN[23:8] == 16'd0 ? TAIL : LONG;
        end
      end else if (VALID && state == LONG) begin
        PVALID <= 1'b1;
        PDATA <= DIN;
        PBE <= last_be;
        PLAST <= rem <= 16'd4;
        CRC_ERR <= rem < 16'd3 && crc_bad;
        rem <= rem > 16'd4 ? rem - 16'd4 : 16'd0;
        state <= rem > 16'd4 ? LONG : rem >= 16'd3 ? TAIL : IDLE;
      end else if (VALID && state == TAIL) begin
        CRC_ERR <= crc_bad;
        state <= IDLE;
      end
    end
  end
endmodule
